// File: rtl/gate_response_checker_if.sv
// ---------------------------------------------------------------------------
// gate_response_checker_if
//
// Purpose : bundles the stimulus/response and status signals that pass
//           between gate_response_checker and the board/system side that
//           hosts the 2-input gate under test.
//
// Signals :
//   start     run request into the checker
//   dut_out   output of the gate under test, into the checker
//   a, b      stimulus driven by the checker (a = vector bit 1, b = bit 0)
//   busy      run in progress
//   done      sticky run-complete flag
//   pass      high with done when no vector mismatched
//   err_count saturating mismatch count (ERR_W bits)
//   fail_vec  bit i set when vector i mismatched
//
// Modports:
//   master  the checker side (drives stimulus and status)
//   slave   the host side (drives start and the gate output)
// ---------------------------------------------------------------------------
interface gate_response_checker_if #(
    parameter int ERR_W = 3
);
    logic             start;
    logic             dut_out;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       fail_vec;

    modport master (
        input  start,
        input  dut_out,
        output a,
        output b,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec
    );

    modport slave (
        output start,
        output dut_out,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec
    );
endinterface

// File: rtl/gate_response_checker.sv
// ---------------------------------------------------------------------------
// gate_response_checker
//
// Purpose : exhaustive self-checking harness for a 2-input gate. Walks the
//           A/B vectors 00, 01, 10, 11, holds each for HOLD_CYCLES cycles,
//           samples the gate output on the following CHECK cycle and compares
//           it against the selected truth table. Reports a saturating
//           mismatch count, a per-vector fail mask and done/pass flags.
//
// Parameters:
//   HOLD_CYCLES  settle cycles per vector before sampling (>= 1)
//   ERR_W        width of err_count (>= 3)
//   FUNC         expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, else AND
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    gate_response_checker_if.master (start, dut_out in;
//          a, b, busy, done, pass, err_count, fail_vec out)
//
// Build option:
//   GATE_CHECK_ABORT_EN  when defined, the first mismatching vector ends the
//                        run immediately (remaining vectors are skipped).
// ---------------------------------------------------------------------------
module gate_response_checker #(
    parameter int HOLD_CYCLES = 100,
    parameter int ERR_W       = 3,
    parameter int FUNC        = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gate_response_checker_if.master bus
);

    // Wide enough to hold HOLD_CYCLES itself, since the counter increments
    // on the last APPLY cycle as well.
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            r_state;
    logic [1:0]        r_vec;
    logic [HC_W-1:0]   r_hold_cnt;
    logic              r_a;
    logic              r_b;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ERR_W-1:0]  r_err_count;
    logic [3:0]        r_fail_vec;

    state_t            w_state;
    logic [1:0]        w_vec;
    logic [HC_W-1:0]   w_hold_cnt;
    logic              w_a;
    logic              w_b;
    logic              w_busy;
    logic              w_done;
    logic              w_pass;
    logic [ERR_W-1:0]  w_err_count;
    logic [3:0]        w_fail_vec;
    logic              w_mismatch;
    logic              w_last;

    // Truth table of the reference gate; vector bit 1 is A, bit 0 is B.
    function automatic logic expected_out(input logic [1:0] vec);
        case (FUNC)
            1:       return vec[1] | vec[0];
            2:       return vec[1] ^ vec[0];
            3:       return ~(vec[1] & vec[0]);
            default: return vec[1] & vec[0];
        endcase
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (&v) return v;
        return v + 1'b1;
    endfunction

    always_comb begin
        w_state     = r_state;
        w_vec       = r_vec;
        w_hold_cnt  = r_hold_cnt;
        w_a         = r_a;
        w_b         = r_b;
        w_busy      = r_busy;
        w_done      = r_done;
        w_pass      = r_pass;
        w_err_count = r_err_count;
        w_fail_vec  = r_fail_vec;
        w_mismatch  = 1'b0;
        w_last      = 1'b0;

        case (r_state)
            IDLE, FINISH: begin
                // Results stay held until a new run is requested.
                if (bus.start) begin
                    w_state     = APPLY;
                    w_vec       = 2'd0;
                    w_hold_cnt  = '0;
                    w_err_count = '0;
                    w_fail_vec  = 4'b0000;
                    w_done      = 1'b0;
                    w_pass      = 1'b0;
                    w_busy      = 1'b1;
                    w_a         = 1'b0;
                    w_b         = 1'b0;
                end
            end

            APPLY: begin
                w_hold_cnt = r_hold_cnt + 1'b1;
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state = CHECK;
                end
            end

            CHECK: begin
                // The only cycle in which dut_out is looked at.
                w_mismatch = (bus.dut_out != expected_out(r_vec));
                if (w_mismatch) begin
                    w_fail_vec[r_vec] = 1'b1;
                    w_err_count       = sat_inc(r_err_count);
                end
`ifdef GATE_CHECK_ABORT_EN
                w_last = (r_vec == 2'd3) || w_mismatch;
`else
                w_last = (r_vec == 2'd3);
`endif
                if (w_last) begin
                    w_state = FINISH;
                    w_busy  = 1'b0;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                    w_done  = 1'b1;
                    w_pass  = (w_err_count == '0);
                end else begin
                    w_state    = APPLY;
                    w_vec      = r_vec + 2'd1;
                    w_hold_cnt = '0;
                    w_a        = w_vec[1];
                    w_b        = w_vec[0];
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_vec       <= 2'd0;
            r_hold_cnt  <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_vec  <= 4'b0000;
        end else begin
            r_state     <= w_state;
            r_vec       <= w_vec;
            r_hold_cnt  <= w_hold_cnt;
            r_a         <= w_a;
            r_b         <= w_b;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_pass      <= w_pass;
            r_err_count <= w_err_count;
            r_fail_vec  <= w_fail_vec;
        end
    end

    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;
    assign bus.fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker with HOLD_CYCLES=4.
// u0 expects AND, u1 expects OR; both see the same modelled gate behaviour.
module tb_gate_response_checker;

    localparam int HOLD  = 4;
    localparam int ERR_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   mode  = 0;   // 0: a&b, 1: stuck 0, 2: a|b, 3: stuck 1

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gate_response_checker_if #(.ERR_W(ERR_W)) bus0 ();
    gate_response_checker_if #(.ERR_W(ERR_W)) bus1 ();

    function automatic logic gate_model(input int m, input logic a, input logic b);
        case (m)
            1:       return 1'b0;
            2:       return a | b;
            3:       return 1'b1;
            default: return a & b;
        endcase
    endfunction

    assign bus0.start   = start;
    assign bus1.start   = start;
    assign bus0.dut_out = gate_model(mode, bus0.a, bus0.b);
    assign bus1.dut_out = gate_model(mode, bus1.a, bus1.b);

    gate_response_checker #(.HOLD_CYCLES(HOLD), .ERR_W(ERR_W), .FUNC(0)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    gate_response_checker #(.HOLD_CYCLES(HOLD), .ERR_W(ERR_W), .FUNC(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;   // reset must win over start
        mode  = 0;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if ({bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000",
                     {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass});
        end
        checks++;
        if (bus0.err_count !== 3'd0 || bus0.fail_vec !== 4'b0000) begin
            failures++;
            $display("FAIL reset_results got err=%0d fv=%b want err=0 fv=0000",
                     bus0.err_count, bus0.fail_vec);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy0=%b busy1=%b want 0 0",
                     bus0.busy, bus1.busy);
        end
    endtask

    task automatic test_and_pass();
        logic [1:0] want_ab;
        int walk_bad;
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        walk_bad = 0;
        for (int j = 0; j < 20; j++) begin
            want_ab = 2'(j / 5);
            checks++;
            if ({bus0.a, bus0.b} !== want_ab || bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
                failures++;
                walk_bad++;
                $display("FAIL and_walk edge=%0d got ab=%b busy=%b done=%b want ab=%b busy=1 done=0",
                         j, {bus0.a, bus0.b}, bus0.busy, bus0.done, want_ab);
            end
            tick();
        end
        checks++;
        if ({bus0.done, bus0.busy, bus0.pass, bus0.a, bus0.b} !== 5'b10100) begin
            failures++;
            $display("FAIL and_finish got done,busy,pass,a,b=%b want 10100",
                     {bus0.done, bus0.busy, bus0.pass, bus0.a, bus0.b});
        end
        checks++;
        if (bus0.err_count !== 3'd0 || bus0.fail_vec !== 4'b0000) begin
            failures++;
            $display("FAIL and_results got err=%0d fv=%b want err=0 fv=0000",
                     bus0.err_count, bus0.fail_vec);
        end
    endtask

    task automatic test_stuck0();
        mode  = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j < 20; j++) tick();
        checks++;
        if (bus0.done !== 1'b0) begin
            failures++;
            $display("FAIL stuck0_early_done got=%b want=0 at edge 19", bus0.done);
        end
        tick();
        checks++;
        if (bus0.done !== 1'b1 || bus0.pass !== 1'b0 || bus0.err_count !== 3'd1 ||
            bus0.fail_vec !== 4'b1000) begin
            failures++;
            $display("FAIL stuck0_results got done=%b pass=%b err=%0d fv=%b want 1 0 1 1000",
                     bus0.done, bus0.pass, bus0.err_count, bus0.fail_vec);
        end
    endtask

    task automatic test_or_gate();
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j < 20; j++) tick();
        tick();
        checks++;
        if (bus0.done !== 1'b1 || bus0.pass !== 1'b0 || bus0.err_count !== 3'd2 ||
            bus0.fail_vec !== 4'b0110) begin
            failures++;
            $display("FAIL or_vs_and got done=%b pass=%b err=%0d fv=%b want 1 0 2 0110",
                     bus0.done, bus0.pass, bus0.err_count, bus0.fail_vec);
        end
        checks++;
        if (bus1.done !== 1'b1 || bus1.pass !== 1'b1 || bus1.err_count !== 3'd0 ||
            bus1.fail_vec !== 4'b0000) begin
            failures++;
            $display("FAIL or_vs_or got done=%b pass=%b err=%0d fv=%b want 1 1 0 0000",
                     bus1.done, bus1.pass, bus1.err_count, bus1.fail_vec);
        end
    endtask

    task automatic test_mid_reset();
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 12; j++) tick();
        checks++;
        if (bus0.err_count !== 3'd1 || {bus0.a, bus0.b} !== 2'b10) begin
            failures++;
            $display("FAIL midrst_pre got err=%0d ab=%b want err=1 ab=10",
                     bus0.err_count, {bus0.a, bus0.b});
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({bus0.busy, bus0.a, bus0.b, bus0.done, bus0.pass} !== 5'b00000 ||
            bus0.err_count !== 3'd0 || bus0.fail_vec !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_clear got busy,a,b,done,pass=%b err=%0d fv=%b want 00000 0 0000",
                     {bus0.busy, bus0.a, bus0.b, bus0.done, bus0.pass},
                     bus0.err_count, bus0.fail_vec);
        end
        tick();
        tick();
        tick();
        checks++;
        if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle got busy=%b done=%b want 0 0", bus0.busy, bus0.done);
        end
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j < 20; j++) tick();
        checks++;
        if (bus0.done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_rerun_early got done=%b want 0 at edge 19", bus0.done);
        end
        tick();
        checks++;
        if (bus0.done !== 1'b1 || bus0.pass !== 1'b1 || bus0.fail_vec !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_rerun got done=%b pass=%b fv=%b want 1 1 0000",
                     bus0.done, bus0.pass, bus0.fail_vec);
        end
    endtask

    task automatic test_start_ignored();
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j < 20; j++) begin
            if (j == 7) start = 1'b1;
            tick();
            start = 1'b0;
            if (j == 8) begin
                checks++;
                if ({bus0.a, bus0.b} !== 2'b01) begin
                    failures++;
                    $display("FAIL ignore_walk got ab=%b want 01 at edge 8", {bus0.a, bus0.b});
                end
            end
        end
        checks++;
        if (bus0.done !== 1'b0) begin
            failures++;
            $display("FAIL ignore_early_done got=%b want=0 at edge 19", bus0.done);
        end
        tick();
        checks++;
        if (bus0.done !== 1'b1 || bus0.err_count !== 3'd2 || bus0.fail_vec !== 4'b0110) begin
            failures++;
            $display("FAIL ignore_results got done=%b err=%0d fv=%b want 1 2 0110",
                     bus0.done, bus0.err_count, bus0.fail_vec);
        end
    endtask

    task automatic test_back_to_back();
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({bus0.done, bus0.busy, bus0.pass} !== 3'b010 || bus0.err_count !== 3'd0 ||
            bus0.fail_vec !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_restart got done,busy,pass=%b err=%0d fv=%b want 010 0 0000",
                     {bus0.done, bus0.busy, bus0.pass}, bus0.err_count, bus0.fail_vec);
        end
        for (int j = 1; j < 20; j++) tick();
        tick();
        checks++;
        if (bus0.done !== 1'b1 || bus0.pass !== 1'b1) begin
            failures++;
            $display("FAIL b2b_finish got done=%b pass=%b want 1 1", bus0.done, bus0.pass);
        end
    endtask

    task automatic test_stuck1();
        mode  = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef GATE_CHECK_ABORT_EN
        for (int j = 1; j < 5; j++) tick();
        checks++;
        if (bus0.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_early_done got=%b want=0 at edge 4", bus0.done);
        end
        tick();
        checks++;
        if (bus0.done !== 1'b1 || bus0.busy !== 1'b0 || bus0.pass !== 1'b0 ||
            bus0.err_count !== 3'd1 || bus0.fail_vec !== 4'b0001) begin
            failures++;
            $display("FAIL abort_results got done=%b busy=%b pass=%b err=%0d fv=%b want 1 0 0 1 0001",
                     bus0.done, bus0.busy, bus0.pass, bus0.err_count, bus0.fail_vec);
        end
`else
        for (int j = 1; j < 20; j++) tick();
        checks++;
        if (bus0.done !== 1'b0) begin
            failures++;
            $display("FAIL stuck1_early_done got=%b want=0 at edge 19", bus0.done);
        end
        tick();
        checks++;
        if (bus0.done !== 1'b1 || bus0.pass !== 1'b0 || bus0.err_count !== 3'd3 ||
            bus0.fail_vec !== 4'b0111) begin
            failures++;
            $display("FAIL stuck1_results got done=%b pass=%b err=%0d fv=%b want 1 0 3 0111",
                     bus0.done, bus0.pass, bus0.err_count, bus0.fail_vec);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_and_pass();
        test_stuck0();
        test_or_gate();
        test_mid_reset();
        test_start_ignored();
        test_back_to_back();
        test_stuck1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Synthesizable self-checking harness for 2-input gate blocks such as the mux-built AND gate. It drives the exhaustive A/B sequence 00, 01, 10, 11 into a gate under test, holding each vector for a programmable settle time. It samples the gate's output and compares it against the expected truth table. It reports a mismatch count, a per-vector fail mask and a pass/done summary. It sits beside the gate on the board or in a system bench, acting as the response side of the stimulus interface.

Parameters:
HOLD_CYCLES, 100, settle cycles per vector before sampling (legal range >= 1)
ERR_W, 3, width of err_count (legal range >= 3)
FUNC, 0, expected function: 0 AND, 1 OR, 2 XOR, 3 NAND; any other value is treated as AND

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  run request, sampled in IDLE/FINISH only
dut_out  in  1  output of gate under test
a  out  1  stimulus A (vector bit 1)
b  out  1  stimulus B (vector bit 0)
busy  out  1  high while a run is in progress
done  out  1  sticky run-complete flag
pass  out  1  high with done when err_count == 0
err_count  out  ERR_W  mismatch count, saturating
fail_vec  out  4  bit i set when vector i mismatched

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous, active-low.
- Reset (rst_n=0 at a rising edge): state=IDLE, vec=0, hold_cnt=0, and all outputs (a, b, busy, done, pass, err_count, fail_vec) go to 0. This applies equally in mid-run; no partial result survives.
- FSM states: IDLE, APPLY, CHECK, FINISH.
- IDLE → APPLY on start=1:
  - clear vec, hold_cnt, err_count and fail_vec; clear done and pass; set busy=1.
- APPLY:
  - {a,b}=vec; hold_cnt increments each cycle.
  - When hold_cnt==HOLD_CYCLES-1, go to CHECK.
- CHECK (one cycle):
  - a and b are still held.
  - dut_out is compared with expected(FUNC, vec).
  - On mismatch: fail_vec[vec]<=1 and err_count<=err_count+1, saturating at all-ones.
  - If vec==3, go to FINISH. Otherwise vec<=vec+1, hold_cnt<=0 and return to APPLY.
- FINISH:
  - busy=0, a=b=0, done=1, pass=(err_count==0); results are held.
  - start=1 restarts exactly as from IDLE.
- Latency: each vector takes HOLD_CYCLES+1 cycles. If start is sampled at edge k, done=1 after edge k+4*(HOLD_CYCLES+1).
- Sampling point: dut_out is sampled only at the CHECK-cycle edge. Glitches during APPLY are ignored.
- start is ignored while busy=1; a pulse mid-run neither restarts the run nor shifts timing.
- rst_n=0 together with start=1: reset wins.
- err_count cannot exceed 4 with ERR_W>=3, so no wrap is possible; saturation is still required.

Optional Feature:
GATE_CHECK_ABORT_EN
- Defined: a mismatch in CHECK sends the FSM directly to FINISH. Remaining vectors are skipped, and done asserts one edge after the failing CHECK with pass=0.
- Undefined: all four vectors always run, as described in Behaviour.

Test Plan:
1. FUNC=0, HOLD_CYCLES=4, dut_out=a&b; pulse start → done=1 exactly 20 edges after start; pass=1, err_count=0, fail_vec=4'b0000; a/b walk 00,01,10,11 with 5 cycles each.
2. FUNC=0, HOLD=4, dut_out stuck at 0 → done after 20 edges; err_count=1, fail_vec=4'b1000, pass=0.
3. FUNC=0, HOLD=4, dut_out=a|b → err_count=2, fail_vec=4'b0110, pass=0; with FUNC=1 on the same DUT → pass=1.
4. Drive rst_n=0 for one edge during vector 2 → next cycle busy=0, a=b=0, err_count=0, state IDLE; a fresh start then completes normally in 20 edges.
5. start pulsed again at edge 7 of a run (HOLD=4) → ignored; done still lands at edge 20 with unchanged results.
6. GATE_CHECK_ABORT_EN defined, HOLD=4, dut_out stuck at 1 → fails vector 0; done=1 at edge 5 after start, err_count=1, fail_vec=4'b0001, pass=0.
